wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter: PRIO_RESET, 0, requester (0 or 1) favoured on the first contention after reset.
REQ-002 Widths XLEN, REG_ADDR_WIDTH and NUM_REG SHALL come from sp_pkg.
REQ-003 Port: clk_i  in  1  global clock, rising edge.
REQ-004 Port: arst_ni  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 Port: p0_valid_i  in  1  requester 0 has a write pending.
REQ-006 Port: p0_ready_o  out  1  requester 0 write accepted this cycle.
REQ-007 Port: p0_addr_i  in  REG_ADDR_WIDTH  requester 0 destination register.
REQ-008 Port: p0_data_i  in  XLEN  requester 0 write data.
REQ-009 Ports p1_valid_i, p1_ready_o, p1_addr_i, p1_data_i SHALL mirror REQ-005..008 for requester 1.
REQ-010 Port: rd_en_o  out  1  register file write enable.
REQ-011 Port: rd_addr_o  out  REG_ADDR_WIDTH  register file write address.
REQ-012 Port: rd_data_o  out  XLEN  register file write data.
REQ-013 Port: wr_pending_o  out  NUM_REG  one-hot of the register being written this cycle.

Function
REQ-014 Transfer on port n SHALL occur when pn_valid_i and pn_ready_o are both 1 at a rising edge.
REQ-015 Exactly zero or one pn_ready_o SHALL be 1 per cycle; pn_ready_o SHALL be 0 whenever pn_valid_i is 0.
REQ-016 Only one valid: that port's ready SHALL be 1 in the same cycle (combinational grant).
REQ-017 Both valid: ready SHALL go to the port selected by the priority pointer ptr_q; the other ready is 0.
REQ-018 ptr_q SHALL update on every transfer to the port that was not granted; no transfer -> ptr_q holds.
REQ-019 Back-to-back contention SHALL alternate grants 0,1,0,1 (no requester waits more than one cycle while the other is valid).
REQ-020 A transfer SHALL register addr/data into the output stage; rd_en_o/rd_addr_o/rd_data_o valid exactly 1 cycle after the transfer edge.
REQ-021 Cycle with no transfer: next-cycle rd_en_o = 0; rd_addr_o and rd_data_o hold last values.
REQ-022 Transfer with addr = 0 SHALL be accepted (ready = 1) but produce rd_en_o = 0; rd_addr_o/rd_data_o still load.
REQ-023 wr_pending_o SHALL equal one-hot(rd_addr_o) when rd_en_o = 1, else all zeros.
REQ-024 Both ports targeting the same address in one cycle: winner written first, loser next cycle; final register value is loser's data.
REQ-025 The block SHALL apply no backpressure from the register file; output stage drains every cycle, sustained throughput one write per cycle.
REQ-026 Requesters SHALL hold valid, addr and data stable until ready; the bench SHALL flag a violation; the design is not required to tolerate one.
REQ-027 Total RTL state: ptr_q, output valid, output addr, output data.

Reset
REQ-028 While arst_ni = 0: rd_en_o = 0, rd_addr_o = 0, rd_data_o = 0, wr_pending_o = 0, ptr_q = PRIO_RESET, p0_ready_o = p1_ready_o = 0.
REQ-029 Reset asserted mid-operation SHALL discard the write held in the output stage immediately (asynchronous), no partial write issued.
REQ-030 First rising edge after arst_ni deasserts SHALL perform normal arbitration per REQ-016..017.

Verification
REQ-031 Single port: p0 valid addr 3 data 0xDEADBEEF -> p0_ready_o = 1 same cycle; next cycle rd_en_o = 1, rd_addr_o = 3, rd_data_o = 0xDEADBEEF, wr_pending_o = 0x08 (NUM_REG = 8).
REQ-032 Contention, PRIO_RESET = 0: both valid (p0 addr 1 data 0x11, p1 addr 2 data 0x22) held 4 cycles -> grants p0,p1,p0,p1; rd_addr_o sequence 1,2,1,2.
REQ-033 Same address: p0 addr 5 data 0xA, p1 addr 5 data 0xB both valid -> writes 0xA then 0xB on consecutive cycles; register 5 ends at 0xB.
REQ-034 x0 write: p1 addr 0 data 0xFFFFFFFF -> p1_ready_o = 1; next cycle rd_en_o = 0, wr_pending_o = 0.
REQ-035 Reset mid-stream: arst_ni low during the cycle rd_en_o = 1 -> rd_en_o drops to 0 before the next clock edge; after release ptr_q = PRIO_RESET and first contention grants that port.
REQ-036 Idle: no valids for 10 cycles -> rd_en_o = 0 throughout, rd_addr_o/rd_data_o unchanged.

Source files
------------

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - two-requester register-file write arbiter with round-robin tie-break
// One registered output stage; a grant is combinational from valid and the priority pointer.
package sp_pkg;
  localparam int XLEN           = 32;
  localparam int NUM_REG        = 8;
  localparam int REG_ADDR_WIDTH = $clog2(NUM_REG);
endpackage

module wb_arbiter
  import sp_pkg::*;
#(
  parameter logic PRIO_RESET = 1'b0
) (
  input  logic                      clk_i,
  input  logic                      arst_ni,
  input  logic                      p0_valid_i,
  output logic                      p0_ready_o,
  input  logic [REG_ADDR_WIDTH-1:0] p0_addr_i,
  input  logic [XLEN-1:0]           p0_data_i,
  input  logic                      p1_valid_i,
  output logic                      p1_ready_o,
  input  logic [REG_ADDR_WIDTH-1:0] p1_addr_i,
  input  logic [XLEN-1:0]           p1_data_i,
  output logic                      rd_en_o,
  output logic [REG_ADDR_WIDTH-1:0] rd_addr_o,
  output logic [XLEN-1:0]           rd_data_o,
  output logic [NUM_REG-1:0]        wr_pending_o
);

  logic                      ptr_q, ptr_d;
  logic                      rd_en_q, rd_en_d;
  logic [REG_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [XLEN-1:0]           rd_data_q, rd_data_d;

  logic                      grant0, grant1, xfer;
  logic [REG_ADDR_WIDTH-1:0] sel_addr;
  logic [XLEN-1:0]           sel_data;

  // ptr_q names the port that wins when both are valid.
  always_comb begin
    grant0   = 1'b0;
    grant1   = 1'b0;
    if (arst_ni) begin
      grant0 = p0_valid_i && (!p1_valid_i || (ptr_q == 1'b0));
      grant1 = p1_valid_i && (!p0_valid_i || (ptr_q == 1'b1));
    end
    xfer     = grant0 || grant1;
    sel_addr = grant1 ? p1_addr_i : p0_addr_i;
    sel_data = grant1 ? p1_data_i : p0_data_i;
  end

  always_comb begin
    ptr_d     = ptr_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    if (grant0) ptr_d = 1'b1;
    if (grant1) ptr_d = 1'b0;
    if (xfer) begin
      // Register 0 is hardwired: the write is accepted but never enabled.
      rd_en_d   = (sel_addr != '0);
      rd_addr_d = sel_addr;
      rd_data_d = sel_data;
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      ptr_q     <= PRIO_RESET;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
    end else begin
      ptr_q     <= ptr_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign p0_ready_o   = grant0;
  assign p1_ready_o   = grant1;
  assign rd_en_o      = rd_en_q;
  assign rd_addr_o    = rd_addr_q;
  assign rd_data_o    = rd_data_q;
  assign wr_pending_o = rd_en_q ? (NUM_REG'(1) << rd_addr_q) : '0;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed vector bench for wb_arbiter
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_wb_arbiter;
  import sp_pkg::*;

  logic                      clk_i = 1'b0;
  logic                      arst_ni;
  logic                      p0_valid_i, p1_valid_i;
  logic                      p0_ready_o, p1_ready_o;
  logic [REG_ADDR_WIDTH-1:0] p0_addr_i, p1_addr_i;
  logic [XLEN-1:0]           p0_data_i, p1_data_i;
  logic                      rd_en_o;
  logic [REG_ADDR_WIDTH-1:0] rd_addr_o;
  logic [XLEN-1:0]           rd_data_o;
  logic [NUM_REG-1:0]        wr_pending_o;

  wb_arbiter #(.PRIO_RESET(1'b0)) dut (
    .clk_i(clk_i), .arst_ni(arst_ni),
    .p0_valid_i(p0_valid_i), .p0_ready_o(p0_ready_o), .p0_addr_i(p0_addr_i), .p0_data_i(p0_data_i),
    .p1_valid_i(p1_valid_i), .p1_ready_o(p1_ready_o), .p1_addr_i(p1_addr_i), .p1_data_i(p1_data_i),
    .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o), .wr_pending_o(wr_pending_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        v0; logic [2:0] a0; logic [31:0] d0;
    logic        v1; logic [2:0] a1; logic [31:0] d1;
    logic        r0; logic r1;
    logic        en; logic [2:0] addr; logic [31:0] data; logic [7:0] wp;
  } vec_t;

  vec_t        vecs[16];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] regs[NUM_REG];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v0, input logic [2:0] a0, input logic [31:0] d0,
                       input logic v1, input logic [2:0] a1, input logic [31:0] d1);
    p0_valid_i = v0; p0_addr_i = a0; p0_data_i = d0;
    p1_valid_i = v1; p1_addr_i = a1; p1_data_i = d1;
  endtask

  task automatic chk_out(input string tag, input logic en, input logic [2:0] addr,
                         input logic [31:0] data, input logic [7:0] wp);
    chk({tag, ".rd_en"}, 64'(rd_en_o), 64'(en));
    chk({tag, ".rd_addr"}, 64'(rd_addr_o), 64'(addr));
    chk({tag, ".rd_data"}, 64'(rd_data_o), 64'(data));
    chk({tag, ".wr_pending"}, 64'(wr_pending_o), 64'(wp));
    if (rd_en_o === 1'b1) regs[rd_addr_o] = rd_data_o;
  endtask

  // Requester-protocol and grant-exclusivity monitor, sampled just before each rising edge.
  logic        pend0 = 1'b0, pend1 = 1'b0;
  logic [2:0]  pa0, pa1;
  logic [31:0] pd0, pd1;
  always @(negedge clk_i) begin
    #3;
    checks++;
    if ((p0_ready_o && p1_ready_o) || (p0_ready_o && !p0_valid_i) || (p1_ready_o && !p1_valid_i)) begin
      errors++;
      $display("FAIL ready_exclusive r0=%0b r1=%0b v0=%0b v1=%0b", p0_ready_o, p1_ready_o, p0_valid_i, p1_valid_i);
    end
    if (pend0 && arst_ni && (!p0_valid_i || p0_addr_i != pa0 || p0_data_i != pd0)) begin
      errors++;
      $display("FAIL p0_hold_violation valid=%0b addr=%0h data=%0h", p0_valid_i, p0_addr_i, p0_data_i);
    end
    if (pend1 && arst_ni && (!p1_valid_i || p1_addr_i != pa1 || p1_data_i != pd1)) begin
      errors++;
      $display("FAIL p1_hold_violation valid=%0b addr=%0h data=%0h", p1_valid_i, p1_addr_i, p1_data_i);
    end
    pend0 = arst_ni && p0_valid_i && !p0_ready_o;
    pend1 = arst_ni && p1_valid_i && !p1_ready_o;
    pa0 = p0_addr_i; pd0 = p0_data_i;
    pa1 = p1_addr_i; pd1 = p1_data_i;
  end

  initial begin
    //            v0 a0 d0             v1 a1 d1             r0 r1 en addr data           wp
    vecs[0]  = '{0, 0, 0,            0, 0, 0,            0, 0, 0, 0, 32'h0,          8'h00};
    vecs[1]  = '{1, 1, 32'h11,       1, 2, 32'h22,       1, 0, 0, 0, 32'h0,          8'h00};
    vecs[2]  = '{1, 1, 32'h11,       1, 2, 32'h22,       0, 1, 1, 1, 32'h11,         8'h02};
    vecs[3]  = '{1, 1, 32'h11,       1, 2, 32'h22,       1, 0, 1, 2, 32'h22,         8'h04};
    vecs[4]  = '{1, 1, 32'h11,       1, 2, 32'h22,       0, 1, 1, 1, 32'h11,         8'h02};
    vecs[5]  = '{1, 1, 32'h11,       0, 0, 0,            1, 0, 1, 2, 32'h22,         8'h04};
    vecs[6]  = '{1, 3, 32'hDEADBEEF, 0, 0, 0,            1, 0, 1, 1, 32'h11,         8'h02};
    vecs[7]  = '{0, 0, 0,            0, 0, 0,            0, 0, 1, 3, 32'hDEADBEEF,   8'h08};
    vecs[8]  = '{0, 0, 0,            1, 4, 32'h44,       0, 1, 0, 3, 32'hDEADBEEF,   8'h00};
    vecs[9]  = '{1, 5, 32'hA,        1, 5, 32'hB,        1, 0, 1, 4, 32'h44,         8'h10};
    vecs[10] = '{0, 0, 0,            1, 5, 32'hB,        0, 1, 1, 5, 32'hA,          8'h20};
    vecs[11] = '{0, 0, 0,            1, 0, 32'hFFFFFFFF, 0, 1, 1, 5, 32'hB,          8'h20};
    vecs[12] = '{0, 0, 0,            0, 0, 0,            0, 0, 0, 0, 32'hFFFFFFFF,   8'h00};
    vecs[13] = '{1, 7, 32'h77,       1, 6, 32'h66,       1, 0, 0, 0, 32'hFFFFFFFF,   8'h00};
    vecs[14] = '{0, 0, 0,            1, 6, 32'h66,       0, 1, 1, 7, 32'h77,         8'h80};
    vecs[15] = '{0, 0, 0,            0, 0, 0,            0, 0, 1, 6, 32'h66,         8'h40};
    foreach (regs[i]) regs[i] = '0;

    arst_ni = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk_i);
    drive(1, 3, 32'h1, 1, 4, 32'h2);
    #1;
    chk("reset.p0_ready", 64'(p0_ready_o), 64'(0));
    chk("reset.p1_ready", 64'(p1_ready_o), 64'(0));
    chk_out("reset", 0, 0, 0, 8'h00);
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk_i);
    arst_ni = 1'b1;

    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk_i);
      drive(vecs[i].v0, vecs[i].a0, vecs[i].d0, vecs[i].v1, vecs[i].a1, vecs[i].d1);
      #1;
      chk($sformatf("v%0d.p0_ready", i), 64'(p0_ready_o), 64'(vecs[i].r0));
      chk($sformatf("v%0d.p1_ready", i), 64'(p1_ready_o), 64'(vecs[i].r1));
      chk_out($sformatf("v%0d", i), vecs[i].en, vecs[i].addr, vecs[i].data, vecs[i].wp);
    end
    chk("reg5_final", 64'(regs[5]), 64'(32'hB));
    chk("reg0_untouched", 64'(regs[0]), 64'(0));

    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      drive(0, 0, 0, 0, 0, 0);
      #1;
      chk_out($sformatf("idle%0d", i), 0, 6, 32'h66, 8'h00);
    end

    // Mid-stream reset: a p0 transfer leaves ptr_q pointing at p1 and a write in the output stage.
    @(negedge clk_i);
    drive(1, 2, 32'h55, 0, 0, 0);
    #1;
    chk("mrst.grant_p0", 64'(p0_ready_o), 64'(1));
    @(negedge clk_i);
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk_out("mrst.pre", 1, 2, 32'h55, 8'h04);
    #1;
    arst_ni = 1'b0;
    drive(1, 1, 32'h11, 1, 2, 32'h22);
    #1;
    chk_out("mrst.async", 0, 0, 0, 8'h00);
    chk("mrst.p0_ready", 64'(p0_ready_o), 64'(0));
    chk("mrst.p1_ready", 64'(p1_ready_o), 64'(0));
    @(negedge clk_i);
    arst_ni = 1'b1;
    #1;
    chk("rel.p0_ready", 64'(p0_ready_o), 64'(1));
    chk("rel.p1_ready", 64'(p1_ready_o), 64'(0));
    @(negedge clk_i);
    drive(0, 0, 0, 1, 2, 32'h22);
    #1;
    chk("rel2.p1_ready", 64'(p1_ready_o), 64'(1));
    chk_out("rel2", 1, 1, 32'h11, 8'h02);
    @(negedge clk_i);
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk_out("rel3", 1, 2, 32'h22, 8'h04);
    @(negedge clk_i);
    #4;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
